// File: rtl/apb_uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_uart_pkg : register map, STATUS bit positions and TX FSM state type
// Revision     : 1.0
// ---------------------------------------------------------------------------
package apb_uart_pkg;

    localparam int unsigned DEFAULT_DIV = 16;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_BAUD   = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_BUSY      = 2;
    localparam int unsigned STAT_COUNT_LSB = 4;

    localparam int unsigned CTRL_TX_EN  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_fifo : byte FIFO feeding the UART transmitter (DEPTH power of 2)
// Revision     : 1.0
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [7:0]             wdata,
    input  logic                   pop,
    output logic [7:0]             rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    import apb_uart_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // count never exceeds DEPTH, so its MSB alone marks the full condition
    assign full   = r_count[AW];
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_uart_tx : APB-programmable 8N1 UART transmitter with TX FIFO and irq
// Revision    : 1.0
// ---------------------------------------------------------------------------
module apb_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = apb_uart_pkg::DEFAULT_DIV
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PADDR,
    input  logic        PSELx,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR,
    output logic        TXD,
    output logic        tx_irq
);
    import apb_uart_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic            w_access;
    logic            w_addr_err;
    logic            w_wr;
    logic            w_data_wr;
    logic [3:0]      w_off;
    logic [31:0]     w_status;
    logic            w_unused;

    logic [15:0]     r_baud;
    logic            r_tx_en;
    logic            r_irq_en;

    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;
    logic [7:0]      w_fifo_rdata;
    logic            w_pop;

    tx_state_e       r_state;
    tx_state_e       w_state_n;
    logic [15:0]     r_cyc;
    logic [15:0]     w_cyc_n;
    logic [15:0]     r_div;
    logic [15:0]     w_div_n;
    logic [15:0]     w_div_load;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_n;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_n;
    logic            w_bit_end;
    logic            w_can_start;
    logic            w_busy;
    logic            r_irq;

    assign w_unused   = &{1'b0, PWDATA[31:16]};

    assign w_access   = PSELx & PENABLE;
    assign w_addr_err = (|PADDR[31:4]) | (|PADDR[1:0]);
    assign w_off      = PADDR[3:0];
    assign w_wr       = w_access & PWRITE & ~w_addr_err;
    assign w_data_wr  = w_wr & (w_off == OFF_DATA);

    assign PREADY  = w_access;
    assign PSLVERR = w_access & (w_addr_err | (w_data_wr & w_fifo_full));

    always_comb begin
        w_status                           = '0;
        w_status[STAT_EMPTY]               = w_fifo_empty;
        w_status[STAT_FULL]                = w_fifo_full;
        w_status[STAT_BUSY]                = w_busy;
        w_status[STAT_COUNT_LSB +: 4]      = 4'(w_fifo_count);
    end

    always_comb begin
        PRDATA = '0;
        if (w_access && !PWRITE && !w_addr_err) begin
            case (w_off)
                OFF_STATUS: PRDATA = w_status;
                OFF_BAUD:   PRDATA = {16'h0, r_baud};
                OFF_CTRL:   PRDATA = {30'h0, r_irq_en, r_tx_en};
                default:    PRDATA = '0;
            endcase
        end
    end

    // STATUS and DATA have no storage here; writes to STATUS fall through
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_baud   <= 16'(DEFAULT_DIV);
            r_tx_en  <= 1'b0;
            r_irq_en <= 1'b0;
        end else if (w_wr) begin
            case (w_off)
                OFF_BAUD: r_baud <= PWDATA[15:0];
                OFF_CTRL: begin
                    r_tx_en  <= PWDATA[CTRL_TX_EN];
                    r_irq_en <= PWDATA[CTRL_IRQ_EN];
                end
                default: ;
            endcase
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (w_data_wr),
        .wdata (PWDATA[7:0]),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign w_div_load  = (r_baud == 16'd0) ? 16'd1 : r_baud;
    assign w_bit_end   = (r_cyc == (r_div - 16'd1));
    assign w_can_start = r_tx_en & ~w_fifo_empty;
    assign w_busy      = (r_state != ST_IDLE);

    always_comb begin
        w_state_n = r_state;
        w_cyc_n   = r_cyc + 16'd1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_div_n   = r_div;
        w_pop     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cyc_n = '0;
                if (w_can_start) begin
                    w_pop     = 1'b1;
                    w_state_n = ST_START;
                    w_shift_n = w_fifo_rdata;
                    w_div_n   = w_div_load;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_cyc_n   = '0;
                    w_bit_n   = '0;
                    w_state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cyc_n   = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    w_bit_n   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_cyc_n = '0;
                    // chain straight into the next frame with no idle bit
                    if (w_can_start) begin
                        w_pop     = 1'b1;
                        w_state_n = ST_START;
                        w_shift_n = w_fifo_rdata;
                        w_div_n   = w_div_load;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_cyc   <= '0;
            r_div   <= 16'd1;
            r_bit   <= '0;
            r_shift <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cyc   <= w_cyc_n;
            r_div   <= w_div_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_irq   <= r_irq_en & w_fifo_empty & ~w_busy;
        end
    end

    assign TXD    = (r_state == ST_START) ? 1'b0 :
                    (r_state == ST_DATA)  ? r_shift[0] : 1'b1;
    assign tx_irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_uart_tx : directed + randomized APB traffic checked against a
//                  queue-based line model of the transmitter
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_uart_tx;

    localparam int DEPTH = 8;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic        pready;
    logic        pslverr;
    logic        txd;
    logic        irq;
    logic [31:0] prdata;

    apb_uart_tx #(
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PADDR   (paddr),
        .PSELx   (psel),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PWDATA  (pwdata),
        .PREADY  (pready),
        .PRDATA  (prdata),
        .PSLVERR (pslverr),
        .TXD     (txd),
        .tx_irq  (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Line model: m_txq holds every TXD value still to be emitted, one per cycle
    bit              m_valid = 1'b0;
    logic [7:0]      m_fifo[$];
    bit              m_txq[$];
    logic [15:0]     m_baud;
    bit              m_tx_en;
    bit              m_irq_en;
    bit              m_irq;

    logic            obs_txd, obs_irq, obs_pready, obs_pslverr;
    logic [31:0]     obs_prdata;

    logic [31:0] addrs [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h2, 32'h80000004, 32'h100};
    logic [9:0]  a5_frame  = 10'b11_0100_1010;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit aerr(input logic [31:0] a);
        return (a[31:4] != 0) || (a[1:0] != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] off);
        int sz;
        sz = m_fifo.size();
        case (off)
            4'h4:    return {24'h0, 4'(sz), 1'b0, (m_txq.size() != 0), (sz == DEPTH), (sz == 0)};
            4'h8:    return {16'h0, m_baud};
            4'hC:    return {30'h0, m_irq_en, m_tx_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic compare();
        bit          e_ready, e_err;
        logic [31:0] e_rd;
        e_ready = psel & penable;
        e_err   = e_ready & (aerr(paddr) | (pwrite & (paddr == 32'h0) & (m_fifo.size() == DEPTH)));
        e_rd    = (e_ready && !pwrite && !aerr(paddr)) ? m_read(paddr[3:0]) : 32'h0;
        check("txd",     {31'h0, txd},     {31'h0, (m_txq.size() != 0) ? m_txq[0] : 1'b1});
        check("tx_irq",  {31'h0, irq},     {31'h0, m_irq});
        check("pready",  {31'h0, pready},  {31'h0, e_ready});
        check("pslverr", {31'h0, pslverr}, {31'h0, e_err});
        check("prdata",  prdata,           e_rd);
    endtask

    task automatic model_update();
        bit         was_empty, was_full, was_busy, wr;
        logic [7:0] b;
        int         d;
        if (!rst_n) begin
            m_fifo.delete();
            m_txq.delete();
            m_baud   = 16'd16;
            m_tx_en  = 1'b0;
            m_irq_en = 1'b0;
            m_irq    = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            was_empty = (m_fifo.size() == 0);
            was_full  = (m_fifo.size() == DEPTH);
            was_busy  = (m_txq.size() != 0);
            wr        = psel & penable & pwrite & !aerr(paddr);
            m_irq     = m_irq_en & was_empty & !was_busy;
            if (m_txq.size() != 0) void'(m_txq.pop_front());
            if (m_tx_en && !was_empty && m_txq.size() == 0) begin
                b = m_fifo.pop_front();
                d = (m_baud == 0) ? 1 : int'(m_baud);
                for (int i = 0; i < 10; i++) begin
                    bit v;
                    if (i == 0)      v = 1'b0;
                    else if (i == 9) v = 1'b1;
                    else             v = b[i-1];
                    repeat (d) m_txq.push_back(v);
                end
            end
            if (wr) begin
                case (paddr[3:0])
                    4'h0: if (!was_full) m_fifo.push_back(pwdata[7:0]);
                    4'h8: m_baud = pwdata[15:0];
                    4'hC: begin
                        m_tx_en  = pwdata[0];
                        m_irq_en = pwdata[1];
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (m_valid) compare();
        obs_txd     = txd;
        obs_irq     = irq;
        obs_pready  = pready;
        obs_pslverr = pslverr;
        obs_prdata  = prdata;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        step();
        penable = 1'b1;
        step();
        err = obs_pslverr;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        step();
        penable = 1'b1;
        step();
        d   = obs_prdata;
        err = obs_pslverr;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_start(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            if (obs_txd === 1'b0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: no start bit within %0d cycles", bound);
        end
    endtask

    logic [31:0] rd;
    logic        err;
    int          n;
    bit          got;
    int unsigned op;
    logic [31:0] a;
    logic [31:0] d;

    initial begin
        // reset defaults
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset_txd", {31'h0, obs_txd}, 32'h1);
        check("reset_irq", {31'h0, obs_irq}, 32'h0);
        apb_read(32'h8, rd, err);
        check("reset_baud", rd, 32'h10);
        apb_read(32'h4, rd, err);
        check("reset_status", rd, 32'h1);

        // single 0xA5 frame at divider 4
        apb_write(32'h8, 32'd4, err);
        apb_write(32'hC, 32'd1, err);
        apb_write(32'h0, 32'hA5, err);
        wait_start(20);
        for (int k = 0; k < 40; k++) begin
            if (k != 0) step();
            check("a5_bit", {31'h0, obs_txd}, {31'h0, a5_frame[k/4]});
        end
        step();
        apb_read(32'h4, rd, err);
        check("a5_done_status", rd, 32'h1);

        // fill FIFO with transmitter disabled
        apb_write(32'hC, 32'd0, err);
        for (int k = 0; k < 9; k++) begin
            apb_write(32'h0, 32'(k + 1), err);
            check("fill_pslverr", {31'h0, err}, (k < 8) ? 32'h0 : 32'h1);
        end
        apb_read(32'h4, rd, err);
        check("full_status", rd, 32'h82);

        // two back-to-back frames, interrupt after drain
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        apb_write(32'h0, 32'h3C, err);
        apb_write(32'h0, 32'hC3, err);
        apb_write(32'h8, 32'd2, err);
        apb_write(32'hC, 32'd3, err);
        wait_start(20);
        n = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            step();
            n++;
            if (obs_irq === 1'b1) got = 1'b1;
        end
        check("irq_latency", 32'(n), 32'd41);

        // bad address and setup-only cycle
        apb_read(32'h10, rd, err);
        check("bad_pready", {31'h0, obs_pready}, 32'h1);
        check("bad_pslverr", {31'h0, err}, 32'h1);
        check("bad_prdata", rd, 32'h0);
        paddr = 32'h8; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        step();
        check("setup_pready", {31'h0, obs_pready}, 32'h0);
        psel = 1'b0;
        apb_read(32'h8, rd, err);
        check("baud_kept", rd, 32'h2);

        // reset in the middle of data bit 3
        apb_write(32'h8, 32'd4, err);
        apb_write(32'hC, 32'd1, err);
        apb_write(32'h0, 32'h5A, err);
        wait_start(20);
        repeat (17) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("midreset_txd", {31'h0, obs_txd}, 32'h1);
        apb_read(32'h4, rd, err);
        check("midreset_status", rd, 32'h1);
        apb_read(32'h8, rd, err);
        check("midreset_baud", rd, 32'h10);

        // randomized traffic, every cycle checked against the line model
        apb_write(32'h8, 32'd1, err);
        for (int t = 0; t < 600; t++) begin
            op = $urandom_range(0, 99);
            if (op < 2) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                apb_write(32'h8, 32'($urandom_range(0, 3)), err);
            end else if (op < 45) begin
                apb_write(32'h0, 32'($urandom_range(0, 255)), err);
            end else if (op < 55) begin
                apb_write(32'h8, 32'($urandom_range(0, 3)), err);
            end else if (op < 65) begin
                d = {30'h0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)};
                apb_write(32'hC, d, err);
            end else if (op < 80) begin
                apb_read(addrs[$urandom_range(0, 7)], rd, err);
            end else if (op < 90) begin
                a = addrs[$urandom_range(0, 7)];
                d = $urandom();
                if (a == 32'h8) d = d & 32'h3;
                apb_write(a, d, err);
            end else begin
                repeat ($urandom_range(1, 30)) step();
            end
        end
        apb_write(32'hC, 32'd3, err);
        repeat (400) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
